weight_programmer: RTL and testbench

- Bus initiator that programs coupling weights into the Ising core matrix weight port.
- Drives the core's wready, wr_addr, wdata and rd_addr, and samples rdata.
- Accepts single-cell write commands, or a fill command that sweeps all NxN cells. Optional read-back verifies every write.
- Sits between the host register block and the core matrix, on the AXI clock domain.

---
 rtl/weight_programmer_pkg.sv | 31 +++
 rtl/weight_programmer.sv | 189 ++++++++++++++++++
 tb/tb_weight_programmer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_programmer_pkg.sv
// Shared definitions for the weight programmer: core address layout, FSM
// state encoding and the cell address helper.
`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'h01
`endif

package weight_programmer_pkg;

  localparam int unsigned ADDR_D_LSB   = 13;
  localparam int unsigned ADDR_S_LSB   = 2;
  localparam int unsigned ADDR_FIELD_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
    ST_NEXT  = 3'd4
  } wp_state_e;

  function automatic logic [31:0] weight_addr(input logic [ADDR_FIELD_W-1:0] s,
                                              input logic [ADDR_FIELD_W-1:0] d);
    logic [31:0] a;
    a = '0;
    a[31:24] = `WEIGHT_ADDR_MASK;
    a[ADDR_D_LSB +: ADDR_FIELD_W] = d;
    a[ADDR_S_LSB +: ADDR_FIELD_W] = s;
    return a;
  endfunction

endpackage

// File: rtl/weight_programmer.sv
// Programs coupling weights into the Ising core matrix, one cell or a full
// sweep, with optional read-back verify and sticky mismatch reporting.
//
// state | meaning
// IDLE  | ready for a command
// WRITE | one-cycle write strobe for the cursor cell
// READ  | hold rd_addr for RD_LATENCY cycles
// CHECK | compare rdata with the latched weight
// NEXT  | finish command or advance fill cursor
module weight_programmer
  import weight_programmer_pkg::*;
#(
  parameter int N          = 8,
  parameter int RD_LATENCY = 1,
  parameter int CMP_W      = 8,
  parameter int SKIP_DIAG  = 1,
  localparam int IDXW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            axi_rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_fill,
  input  logic [IDXW-1:0] cmd_s,
  input  logic [IDXW-1:0] cmd_d,
  input  logic [31:0]     cmd_weight,
  input  logic            verify_en,
  output logic            wready,
  output logic [31:0]     wr_addr,
  output logic [31:0]     wdata,
  output logic [31:0]     rd_addr,
  input  logic [31:0]     rdata,
  output logic            busy,
  output logic            done,
  output logic            err_flag,
  output logic [15:0]     err_count,
  output logic [IDXW-1:0] err_s,
  output logic [IDXW-1:0] err_d,
  input  logic            clear_err
);

  localparam int CNTW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int PADW = ADDR_FIELD_W - IDXW;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] LAST_S  = IDXW'((SKIP_DIAG != 0) ? N - 2 : N - 1);
  localparam logic [IDXW-1:0] FILL_S0 = IDXW'((SKIP_DIAG != 0) ? 1 : 0);
  localparam logic [31:0] CMP_MASK =
    (CMP_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CMP_W) - 32'd1);

  wp_state_e       state_q, state_d;
  logic [IDXW-1:0] cur_s_q, cur_s_d;
  logic [IDXW-1:0] cur_d_q, cur_d_d;
  logic [CNTW-1:0] lat_q, lat_d;
  logic            fill_q, verify_q;
  logic [31:0]     weight_q;

  logic            err_flag_q, err_flag_d;
  logic [15:0]     err_count_q, err_count_d;
  logic [IDXW-1:0] err_s_q, err_s_d;
  logic [IDXW-1:0] err_d_q, err_d_d;

  logic            cmd_accept;
  logic            last_cell;
  logic            mismatch;
  logic [IDXW-1:0] step_s, step_d, adv_s, adv_d;
  logic [31:0]     cell_addr;

  assign cmd_accept = (state_q == ST_IDLE) && cmd_valid;
  assign last_cell  = !fill_q || ((cur_s_q == LAST_S) && (cur_d_q == IDX_MAX));
  assign cell_addr  = weight_addr({{PADW{1'b0}}, cur_s_q}, {{PADW{1'b0}}, cur_d_q});
  assign mismatch   = (state_q == ST_CHECK) && (((rdata ^ weight_q) & CMP_MASK) != '0);

  // Fill order: s is the inner loop; a diagonal hit is stepped over once more.
  always_comb begin
    step_s = cur_s_q + 1'b1;
    step_d = cur_d_q;
    if (cur_s_q == IDX_MAX) step_d = cur_d_q + 1'b1;
    adv_s = step_s;
    adv_d = step_d;
    if ((SKIP_DIAG != 0) && (step_s == step_d)) begin
      adv_s = step_s + 1'b1;
      if (step_s == IDX_MAX) adv_d = step_d + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_s_d = cur_s_q;
    cur_d_d = cur_d_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          state_d = ST_WRITE;
          cur_s_d = cmd_fill ? FILL_S0 : cmd_s;
          cur_d_d = cmd_fill ? '0 : cmd_d;
        end
      end
      ST_WRITE: begin
        if (verify_q) begin
          state_d = ST_READ;
          lat_d   = CNTW'(RD_LATENCY - 1);
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_READ: begin
        if (lat_q == '0) state_d = ST_CHECK;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_CHECK: state_d = ST_NEXT;
      ST_NEXT: begin
        if (last_cell) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
          cur_s_d = adv_s;
          cur_d_d = adv_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear in the same cycle as a mismatch still records that mismatch.
  always_comb begin
    err_flag_d  = clear_err ? mismatch : (err_flag_q | mismatch);
    err_count_d = err_count_q;
    err_s_d     = err_s_q;
    err_d_d     = err_d_q;
    if (clear_err) begin
      err_count_d = {15'd0, mismatch};
    end else if (mismatch && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
    if (mismatch && (clear_err || !err_flag_q)) begin
      err_s_d = cur_s_q;
      err_d_d = cur_d_q;
    end else if (clear_err) begin
      err_s_d = '0;
      err_d_d = '0;
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q     <= ST_IDLE;
      cur_s_q     <= '0;
      cur_d_q     <= '0;
      lat_q       <= '0;
      fill_q      <= 1'b0;
      verify_q    <= 1'b0;
      weight_q    <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      err_s_q     <= '0;
      err_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_s_q     <= cur_s_d;
      cur_d_q     <= cur_d_d;
      lat_q       <= lat_d;
      if (cmd_accept) begin
        fill_q   <= cmd_fill;
        verify_q <= verify_en;
        weight_q <= cmd_weight;
      end
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      err_s_q     <= err_s_d;
      err_d_q     <= err_d_d;
    end
  end

  // Core muxes addr on wready, so rd_addr stays valid through READ and CHECK.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wready    = (state_q == ST_WRITE);
  assign wr_addr   = wready ? cell_addr : '0;
  assign wdata     = wready ? weight_q : '0;
  assign rd_addr   = ((state_q == ST_READ) || (state_q == ST_CHECK)) ? cell_addr : '0;
  assign done      = (state_q == ST_NEXT) && last_cell;

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
  assign err_s     = err_s_q;
  assign err_d     = err_d_q;

endmodule

// File: tb/tb_weight_programmer.sv
// Self-checking bench for weight_programmer with a behavioural core memory model.
module tb_weight_programmer;

  localparam int N    = 8;
  localparam int RL   = 2;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            axi_rstn = 1'b0;
  logic            cmd_valid = 1'b0, cmd_fill = 1'b0, verify_en = 1'b0, clear_err = 1'b0;
  logic [IDXW-1:0] cmd_s = '0, cmd_d = '0;
  logic [31:0]     cmd_weight = '0;
  logic            cmd_ready, wready, busy, done, err_flag;
  logic [31:0]     wr_addr, wdata, rd_addr, rdata;
  logic [15:0]     err_count;
  logic [IDXW-1:0] err_s, err_d;

  int total = 0;
  int bad = 0;

  weight_programmer #(.N(N), .RD_LATENCY(RL), .CMP_W(8), .SKIP_DIAG(1)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill(cmd_fill), .cmd_s(cmd_s), .cmd_d(cmd_d), .cmd_weight(cmd_weight),
    .verify_en(verify_en), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
    .rd_addr(rd_addr), .rdata(rdata), .busy(busy), .done(done), .err_flag(err_flag),
    .err_count(err_count), .err_s(err_s), .err_d(err_d), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Core model: memory plus an RL-deep read pipeline, optional corruption.
  logic [31:0] mem [N][N];
  logic [31:0] pipe0 = '0, pipe1 = '0;
  bit          corrupt_all = 1'b0;
  int          corrupt_s = -1, corrupt_d = -1;
  logic [31:0] corrupt_xor = 32'h1;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  always @(posedge clk) begin : core_model
    logic [31:0] v;
    int rs, rdi;
    rs  = int'(rd_addr[2 +: IDXW]);
    rdi = int'(rd_addr[13 +: IDXW]);
    v = mem[rs][rdi];
    if (corrupt_all || (rs == corrupt_s && rdi == corrupt_d)) v = v ^ corrupt_xor;
    if (wready) begin
      mem[wr_addr[2 +: IDXW]][wr_addr[13 +: IDXW]] <= wdata;
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wdata);
    end
    pipe0 <= v;
    pipe1 <= pipe0;
  end
  assign rdata = pipe1;

  function automatic logic [31:0] exp_addr(input int s, input int d);
    return 32'h0100_0000 | (32'(d) << 13) | (32'(s) << 2);
  endfunction

  int ref_s[$];
  int ref_d[$];
  task automatic build_fill_ref();
    ref_s.delete();
    ref_d.delete();
    for (int d = 0; d < N; d++)
      for (int s = 0; s < N; s++)
        if (s != d) begin ref_s.push_back(s); ref_d.push_back(d); end
  endtask

  int          r_done_cyc, r_done_pulses, r_busy_low;
  logic        r_ready_after, r_flag_post;
  logic [15:0] r_cnt_pre, r_cnt_post;
  logic [IDXW-1:0] r_es_post, r_ed_post;

  task automatic run_cmd(input bit fill, input int s, input int d, input logic [31:0] w,
                         input bit ver, input int clear_at);
    int cyc;
    bit seen;
    r_done_cyc = -1; r_done_pulses = 0; r_busy_low = 0; r_ready_after = 1'b0;
    wlog_addr.delete(); wlog_data.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_fill = fill; cmd_s = IDXW'(s); cmd_d = IDXW'(d);
    cmd_weight = w; verify_en = ver;
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (cyc < 1000 && !(seen && cyc >= r_done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin cmd_valid = 1'b0; verify_en = 1'b0; cmd_weight = ~w; end
      if (clear_at > 0 && cyc == clear_at) begin r_cnt_pre = err_count; clear_err = 1'b1; end
      if (clear_at > 0 && cyc == clear_at + 1) begin
        clear_err = 1'b0; r_cnt_post = err_count; r_flag_post = err_flag;
        r_es_post = err_s; r_ed_post = err_d;
      end
      if (!seen && !busy) r_busy_low++;
      if (done) begin
        r_done_pulses++;
        if (!seen) begin seen = 1'b1; r_done_cyc = cyc; end
      end else if (seen && cyc == r_done_cyc + 1) begin
        r_ready_after = cmd_ready;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%0b exp=0", wready); end
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    total++; if (rd_addr !== 32'h0) begin bad++; $display("FAIL reset_rd_addr got=%0h exp=0", rd_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if ({err_flag, err_count, err_s, err_d} !== '0) begin bad++; $display("FAIL reset_err got=%0h exp=0", {err_flag, err_count, err_s, err_d}); end
    @(negedge clk); axi_rstn = 1'b1;
  endtask

  task automatic test_single();
    run_cmd(1'b0, 3, 5, 32'h2A, 1'b0, 0);
    total++; if (wlog_addr.size() !== 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", wlog_addr.size()); end
    total++; if (wlog_addr.size() < 1 || wlog_addr[0] !== 32'h0100A00C) begin bad++; $display("FAIL single_addr got=%0h exp=0100a00c", (wlog_addr.size() > 0) ? wlog_addr[0] : 32'hx); end
    total++; if (wlog_data.size() < 1 || wlog_data[0] !== 32'h2A) begin bad++; $display("FAIL single_data got=%0h exp=2a", (wlog_data.size() > 0) ? wlog_data[0] : 32'hx); end
    total++; if (r_done_cyc !== 2) begin bad++; $display("FAIL single_done_cycle got=%0d exp=2", r_done_cyc); end
    total++; if (r_ready_after !== 1'b1) begin bad++; $display("FAIL single_ready_after got=%0b exp=1", r_ready_after); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL single_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 8; i++) begin
      int s, d, expc;
      bit ver;
      logic [31:0] w;
      s = $urandom_range(0, N - 1); d = $urandom_range(0, N - 1);
      w = $urandom; ver = 1'($urandom_range(0, 1));
      expc = ver ? 3 + RL : 2;
      run_cmd(1'b0, s, d, w, ver, 0);
      total++; if (wlog_addr.size() !== 1 || wlog_addr[0] !== exp_addr(s, d)) begin bad++; $display("FAIL rand_single_addr[%0d] got=%0h exp=%0h", i, (wlog_addr.size() > 0) ? wlog_addr[0] : 32'hx, exp_addr(s, d)); end
      total++; if (wlog_data.size() !== 1 || wlog_data[0] !== w) begin bad++; $display("FAIL rand_single_data[%0d] got=%0h exp=%0h", i, (wlog_data.size() > 0) ? wlog_data[0] : 32'hx, w); end
      total++; if (r_done_cyc !== expc) begin bad++; $display("FAIL rand_single_done[%0d] got=%0d exp=%0d", i, r_done_cyc, expc); end
    end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL rand_single_err got=%0b exp=0", err_flag); end
  endtask

  task automatic check_fill_log(input string tag, input logic [31:0] w);
    int diag, wrong;
    diag = 0; wrong = 0;
    total++; if (wlog_addr.size() !== ref_s.size()) begin bad++; $display("FAIL %s_write_count got=%0d exp=%0d", tag, wlog_addr.size(), ref_s.size()); end
    for (int i = 0; i < wlog_addr.size(); i++) begin
      if (wlog_addr[i][12:2] == wlog_addr[i][23:13]) diag++;
      if (i >= ref_s.size() || wlog_addr[i] !== exp_addr(ref_s[i], ref_d[i]) || wlog_data[i] !== w) wrong++;
    end
    total++; if (wrong !== 0) begin bad++; $display("FAIL %s_sequence got=%0d_bad_cells exp=0", tag, wrong); end
    total++; if (diag !== 0) begin bad++; $display("FAIL %s_diag_writes got=%0d exp=0", tag, diag); end
    total++; if (r_done_pulses !== 1) begin bad++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, r_done_pulses); end
    total++; if (r_busy_low !== 0) begin bad++; $display("FAIL %s_busy_drop got=%0d exp=0", tag, r_busy_low); end
  endtask

  task automatic test_fill();
    build_fill_ref();
    run_cmd(1'b1, 0, 0, 32'h11, 1'b0, 0);
    check_fill_log("fill", 32'h11);
    total++; if (r_done_cyc !== 2 * N * (N - 1)) begin bad++; $display("FAIL fill_done_cycle got=%0d exp=%0d", r_done_cyc, 2 * N * (N - 1)); end
  endtask

  task automatic test_verify();
    logic [31:0] w;
    build_fill_ref();
    corrupt_all = 1'b0; corrupt_s = -1; corrupt_d = -1; corrupt_xor = 32'h1;
    w = $urandom;
    run_cmd(1'b1, 0, 0, w, 1'b1, 0);
    check_fill_log("vfill", w);
    total++; if (r_done_cyc !== (3 + RL) * N * (N - 1)) begin bad++; $display("FAIL vfill_done_cycle got=%0d exp=%0d", r_done_cyc, (3 + RL) * N * (N - 1)); end
    total++; if (err_flag !== 1'b0 || err_count !== 16'd0) begin bad++; $display("FAIL vfill_clean got=%0b/%0d exp=0/0", err_flag, err_count); end
    // Corruption above the compared bits must go unnoticed.
    corrupt_s = 2; corrupt_d = 6; corrupt_xor = 32'h100;
    run_cmd(1'b0, 2, 6, $urandom, 1'b1, 0);
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL verify_high_bits got=%0b exp=0", err_flag); end
    corrupt_xor = 32'h1 << $urandom_range(0, 7);
    run_cmd(1'b1, 0, 0, $urandom, 1'b1, 0);
    total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL verify_err_flag got=%0b exp=1", err_flag); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL verify_err_count got=%0d exp=1", err_count); end
    total++; if (err_s !== 3'd2 || err_d !== 3'd6) begin bad++; $display("FAIL verify_err_cell got=%0d,%0d exp=2,6", err_s, err_d); end
    corrupt_s = -1; corrupt_d = -1;
    pulse_clear();
    total++; if ({err_flag, err_count, err_s, err_d} !== '0) begin bad++; $display("FAIL verify_clear got=%0h exp=0", {err_flag, err_count, err_s, err_d}); end
  endtask

  task automatic test_clear_collision();
    int k;
    build_fill_ref();
    corrupt_all = 1'b1; corrupt_xor = 32'h1;
    k = $urandom_range(2, 6);
    run_cmd(1'b1, 0, 0, $urandom, 1'b1, 4 + (3 + RL) * k);
    corrupt_all = 1'b0;
    total++; if (r_cnt_pre !== 16'(k)) begin bad++; $display("FAIL collide_before got=%0d exp=%0d", r_cnt_pre, k); end
    total++; if (r_cnt_post !== 16'd1 || r_flag_post !== 1'b1) begin bad++; $display("FAIL collide_after got=%0d/%0b exp=1/1", r_cnt_post, r_flag_post); end
    total++; if (int'(r_es_post) !== ref_s[k] || int'(r_ed_post) !== ref_d[k]) begin bad++; $display("FAIL collide_cell got=%0d,%0d exp=%0d,%0d", r_es_post, r_ed_post, ref_s[k], ref_d[k]); end
    total++; if (err_count !== 16'(N * (N - 1) - k)) begin bad++; $display("FAIL collide_final got=%0d exp=%0d", err_count, N * (N - 1) - k); end
    total++; if (int'(err_s) !== ref_s[k] || int'(err_d) !== ref_d[k]) begin bad++; $display("FAIL collide_first_kept got=%0d,%0d exp=%0d,%0d", err_s, err_d, ref_s[k], ref_d[k]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    wlog_addr.delete(); wlog_data.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_weight = 32'h5A; verify_en = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL midrst_pre_wready got=%0b exp=1", wready); end
    #2 axi_rstn = 1'b0;
    #1;
    total++; if (wready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_abort got=%0b/%0b exp=0/0", wready, busy); end
    total++; if (wlog_addr.size() !== 10) begin bad++; $display("FAIL midrst_writes got=%0d exp=10", wlog_addr.size()); end
    @(negedge clk); @(negedge clk); axi_rstn = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", cmd_ready); end
    w = $urandom;
    run_cmd(1'b0, 4, 1, w, 1'b0, 0);
    total++; if (wlog_addr.size() !== 1 || wlog_addr[0] !== exp_addr(4, 1)) begin bad++; $display("FAIL midrst_next_addr got=%0h exp=%0h", (wlog_addr.size() > 0) ? wlog_addr[0] : 32'hx, exp_addr(4, 1)); end
    total++; if (r_done_cyc !== 2) begin bad++; $display("FAIL midrst_next_done got=%0d exp=2", r_done_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb;
    int dones;
    wa = $urandom; wb = $urandom; dones = 0;
    wlog_addr.delete(); wlog_data.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_s = 3'd1; cmd_d = 3'd2; cmd_weight = wa; verify_en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin cmd_s = 3'd6; cmd_d = 3'd3; cmd_weight = wb; verify_en = 1'b0; end
      if (done) dones++;
      if (c == 5) begin total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%0b exp=1", done); end end
      if (c == 6) begin total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", cmd_ready); end end
      if (c == 7) begin
        total++; if (wready !== 1'b1 || wr_addr !== exp_addr(6, 3) || wdata !== wb) begin bad++; $display("FAIL b2b_second_write got=%0b/%0h/%0h exp=1/%0h/%0h", wready, wr_addr, wdata, exp_addr(6, 3), wb); end
        cmd_valid = 1'b0;
      end
      if (c == 8) begin total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%0b exp=1", done); end end
    end
    total++; if (dones !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d exp=2", dones); end
    total++; if (wlog_addr.size() !== 2) begin bad++; $display("FAIL b2b_writes got=%0d exp=2", wlog_addr.size()); end
    total++; if (wlog_addr.size() < 1 || wlog_addr[0] !== exp_addr(1, 2) || wlog_data[0] !== wa) begin bad++; $display("FAIL b2b_first_write got=%0h exp=%0h", (wlog_addr.size() > 0) ? wlog_addr[0] : 32'hx, exp_addr(1, 2)); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b exp=0", err_flag); end
  endtask

  initial begin
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++) mem[s][d] = '0;
    test_reset();
    test_single();
    test_random_single();
    test_fill();
    test_verify();
    test_clear_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
